debounce_multi: RTL

- Parametrised multi-channel debouncer for noisy, asynchronous inputs such as front-panel lines, external trigger/clock-select lines and board jumpers.
- Each channel runs through a synchroniser, then a per-channel stability counter with a programmable threshold.
- Produces a clean level, plus single-cycle rise and fall strobes for the TDC readout and trigger logic.
- Generalises the fixed 3-tap AND debounce: N channels, runtime threshold, symmetric or fast-release mode per channel.

---
 rtl/debounce_multi_pkg.sv | 12 +
 rtl/debounce_chan.sv | 72 +++++++
 rtl/debounce_multi.sv | 44 ++++
 3 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_multi_pkg;

    localparam int unsigned DEB_SYNC_MIN = 2;
    localparam int unsigned DEB_SYNC_MAX = 4;

    // A programmed threshold of zero behaves as one.
    function automatic int unsigned eff_thresh(input int unsigned thresh);
        return (thresh == 0) ? 1 : thresh;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single-bit debouncer: synchroniser, stability counter, level and edge strobes.
module debounce_chan
    import debounce_multi_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic [CNT_W-1:0] thresh,
    input  logic             fast_rel,
    output logic             q,
    output logic             rise,
    output logic             fall
);

    if (SYNC_STAGES < DEB_SYNC_MIN || SYNC_STAGES > DEB_SYNC_MAX) begin : g_bad_sync
        $error("debounce_chan: SYNC_STAGES must be within 2..4");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   s;
    logic                   q_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    int unsigned            thr;

    assign s   = sync[SYNC_STAGES-1];
    assign thr = eff_thresh(32'(thresh));

    always_comb begin
        q_nxt    = q;
        cnt_nxt  = cnt;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (fast_rel && q && !s) begin
            q_nxt    = 1'b0;
            cnt_nxt  = '0;
            fall_nxt = 1'b1;
        end else if (s == q) begin
            cnt_nxt = '0;
        end else if (32'(cnt) >= thr - 1) begin
            // ">=" so a threshold lowered mid-count fires on the next mismatch
            q_nxt    = s;
            cnt_nxt  = '0;
            rise_nxt = s;
            fall_nxt = !s;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            cnt  <= cnt_nxt;
            q    <= q_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer with shared runtime threshold and a delayed any-edge summary.
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  d,
    input  logic [CNT_W-1:0] thresh,
    input  logic [N_CH-1:0]  fast_rel,
    output logic [N_CH-1:0]  q,
    output logic [N_CH-1:0]  rise,
    output logic [N_CH-1:0]  fall,
    output logic             any_edge
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .d        (d[i]),
            .thresh   (thresh),
            .fast_rel (fast_rel[i]),
            .q        (q[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_edge <= 1'b0;
        end else begin
            any_edge <= |(rise | fall);
        end
    end

endmodule
